anton_neopixel_frame_scheduler: RTL and testbench

Sequences the neopixel stream logic frame by frame. It converts software start/stop/abort/bank-swap requests into the stream logic's init and run controls, and tracks frame completion using the stream's pixel-overflow and sync-overflow strobes. It also inserts optional inter-frame gaps, swaps the double-buffer bank only at frame boundaries, and raises completion and watchdog-error status. It sits between the APB register block and the stream logic.

---
 rtl/anton_neopixel_frame_scheduler.sv | 164 ++++++++++++++++
 tb/tb_anton_neopixel_frame_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_frame_scheduler.sv
// Frame sequencer between the APB register block and the neopixel stream.
// Turns software requests into init/run controls, paces frames, swaps banks.
module anton_neopixel_frame_scheduler #(
  parameter int INIT_CYCLES = 2,
  parameter int GAP_BITS    = 16,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic                clk7mhz,
  input  logic                rst,
  input  logic                sw_start,
  input  logic                sw_stop,
  input  logic                sw_abort,
  input  logic                sw_swap,
  input  logic                sw_loop,
  input  logic [GAP_BITS-1:0] sw_gap,
  input  logic                sw_irq_clr,
  input  logic                stream_pixel_of,
  input  logic                stream_sync_of,
  output logic                ctrl_init,
  output logic                ctrl_run,
  output logic                bank_sel,
  output logic                busy,
  output logic                frame_done,
  output logic                irq_done,
  output logic                irq_err,
  output logic [15:0]         frame_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_SYNC,
    S_GAP
  } state_t;

  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WDOG_CYCLES - 1);
  localparam logic [GAP_BITS-1:0] INIT_LD = GAP_BITS'(INIT_CYCLES);
  localparam logic [GAP_BITS-1:0] ONE = GAP_BITS'(1);

  state_t              state, state_n;
  logic [GAP_BITS-1:0] cnt, cnt_n;
  logic [WW-1:0]       wd, wd_n;
  logic                stop_pend, stop_n;
  logic                swap_pend, swap_n;
  logic                bank_n;
  logic                fd_n;
  logic                err_n;
  logic [15:0]         fc_n;

  // Next state, counters and pending flags; abort/watchdog override last.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wd_n    = '0;
    stop_n  = stop_pend | (sw_stop & (state != S_IDLE));
    swap_n  = swap_pend | sw_swap;
    bank_n  = bank_sel;
    fd_n    = 1'b0;
    err_n   = 1'b0;
    fc_n    = frame_count;

    unique case (state)
      S_IDLE: begin
        if (sw_start && !sw_stop && !sw_abort) begin
          state_n = S_INIT;
          cnt_n   = INIT_LD;
          fc_n    = '0;
          stop_n  = 1'b0;
        end
      end
      S_INIT: begin
        if (cnt <= ONE) state_n = S_RUN;
        else cnt_n = cnt - ONE;
      end
      S_RUN: begin
        if (stream_pixel_of) state_n = S_SYNC;
      end
      S_SYNC: begin
        if (stream_sync_of) begin
          fd_n = 1'b1;
          fc_n = frame_count + 16'd1;
          if (swap_n) begin
            bank_n = ~bank_sel;
            swap_n = 1'b0;
          end
          if (stop_n || !sw_loop) begin
            state_n = S_IDLE;
            stop_n  = 1'b0;
          end else if (sw_gap != '0) begin
            state_n = S_GAP;
            cnt_n   = sw_gap;
          end else begin
            state_n = S_RUN;
          end
        end
      end
      S_GAP: begin
        if (cnt <= ONE) begin
          if (stop_n) begin
            state_n = S_IDLE;
            stop_n  = 1'b0;
          end else begin
            state_n = S_RUN;
          end
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if ((state == S_RUN || state == S_SYNC) && state_n == state) begin
      if (wd == WD_LAST) err_n = 1'b1;
      else wd_n = wd + WW'(1);
    end

    if (err_n || (sw_abort && state != S_IDLE)) begin
      state_n = S_IDLE;
      stop_n  = 1'b0;
      swap_n  = 1'b0;
      fd_n    = 1'b0;
      fc_n    = frame_count;
      bank_n  = bank_sel;
      cnt_n   = '0;
      wd_n    = '0;
    end
  end

  // State, counters and registered outputs; sticky status with set priority.
  always_ff @(posedge clk7mhz or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      wd          <= '0;
      stop_pend   <= 1'b0;
      swap_pend   <= 1'b0;
      bank_sel    <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      ctrl_init   <= 1'b0;
      ctrl_run    <= 1'b0;
      busy        <= 1'b0;
      irq_done    <= 1'b0;
      irq_err     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      wd          <= wd_n;
      stop_pend   <= stop_n;
      swap_pend   <= swap_n;
      bank_sel    <= bank_n;
      frame_done  <= fd_n;
      frame_count <= fc_n;
      ctrl_init   <= (state_n == S_INIT);
      ctrl_run    <= (state_n == S_RUN) || (state_n == S_SYNC);
      busy        <= (state_n != S_IDLE);
      irq_done    <= frame_done | (irq_done & ~sw_irq_clr);
      irq_err     <= err_n | (irq_err & ~sw_irq_clr);
    end
  end

endmodule

// File: tb/tb_anton_neopixel_frame_scheduler.sv
// Scoreboard bench for the neopixel frame scheduler.
// Frame expectations are queued by the stimulus and popped on frame_done.
module tb_anton_neopixel_frame_scheduler;

  localparam int INIT = 2;
  localparam int WDOG = 100;

  logic        clk7mhz = 1'b0;
  logic        rst = 1'b1;
  logic        sw_start = 1'b0;
  logic        sw_stop = 1'b0;
  logic        sw_abort = 1'b0;
  logic        sw_swap = 1'b0;
  logic        sw_loop = 1'b0;
  logic [15:0] sw_gap = '0;
  logic        sw_irq_clr = 1'b0;
  logic        stream_pixel_of = 1'b0;
  logic        stream_sync_of = 1'b0;
  logic        ctrl_init;
  logic        ctrl_run;
  logic        bank_sel;
  logic        busy;
  logic        frame_done;
  logic        irq_done;
  logic        irq_err;
  logic [15:0] frame_count;

  anton_neopixel_frame_scheduler #(
    .INIT_CYCLES(INIT),
    .GAP_BITS(16),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk7mhz(clk7mhz),
    .rst(rst),
    .sw_start(sw_start),
    .sw_stop(sw_stop),
    .sw_abort(sw_abort),
    .sw_swap(sw_swap),
    .sw_loop(sw_loop),
    .sw_gap(sw_gap),
    .sw_irq_clr(sw_irq_clr),
    .stream_pixel_of(stream_pixel_of),
    .stream_sync_of(stream_sync_of),
    .ctrl_init(ctrl_init),
    .ctrl_run(ctrl_run),
    .bank_sel(bank_sel),
    .busy(busy),
    .frame_done(frame_done),
    .irq_done(irq_done),
    .irq_err(irq_err),
    .frame_count(frame_count)
  );

  always #5 clk7mhz = ~clk7mhz;

  typedef struct packed {
    logic [15:0] cnt;
    logic        bank;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  logic [15:0] m_count = '0;
  logic        m_bank = 1'b0;
  logic        m_swap = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk7mhz);
    #1;
  endtask

  // Monitor: each frame_done must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk7mhz);
      if (!rst && frame_done) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame_done: got count %0h expected none",
                   frame_count);
        end else begin
          e = q.pop_front();
          chk("fd_count", 32'(frame_count), 32'(e.cnt));
          chk("fd_bank", 32'(bank_sel), 32'(e.bank));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic start_run();
    int n;
    sw_start = 1'b1;
    cyc();
    sw_start = 1'b0;
    m_count = '0;
    chk("init_run_low", 32'(ctrl_run), 0);
    n = 0;
    while (ctrl_init && n < 20) begin
      n++;
      cyc();
    end
    chk("init_len", n, INIT);
    chk("run_after_init", 32'(ctrl_run), 1);
  endtask

  task automatic run_frame(input int rl, input int sl, input bit swm,
                           input bit sws, input bit stm);
    exp_t e;
    for (int i = 0; i < rl; i++) begin
      if (i == 0) begin
        chk("run_high", 32'(ctrl_run), 1);
        chk("bank_hold", 32'(bank_sel), 32'(m_bank));
      end
      if (i == rl / 2) begin
        sw_swap = swm;
        sw_stop = stm;
        if (swm) m_swap = 1'b1;
      end
      cyc();
      sw_swap = 1'b0;
      sw_stop = 1'b0;
    end
    stream_pixel_of = 1'b1;
    cyc();
    stream_pixel_of = 1'b0;
    for (int i = 0; i < sl; i++) begin
      if (i == 0) chk("sync_run_high", 32'(ctrl_run), 1);
      cyc();
    end
    chk("bank_pre_sync", 32'(bank_sel), 32'(m_bank));
    if (sws) m_swap = 1'b1;
    m_count = m_count + 16'd1;
    if (m_swap) begin
      m_bank = ~m_bank;
      m_swap = 1'b0;
    end
    e.cnt = m_count;
    e.bank = m_bank;
    q.push_back(e);
    stream_sync_of = 1'b1;
    sw_swap = sws;
    cyc();
    stream_sync_of = 1'b0;
    sw_swap = 1'b0;
  endtask

  task automatic measure_gap(input int g);
    int n;
    if (g == 0) begin
      chk("zero_gap_run", 32'(ctrl_run), 1);
    end else begin
      n = 0;
      while (!ctrl_run && n < 100) begin
        n++;
        cyc();
      end
      chk("gap_len", n, g);
    end
  endtask

  initial begin
    int n;
    int gap;
    int nf;
    repeat (3) @(posedge clk7mhz);
    #1;
    rst = 1'b0;
    chk("rst_init", 32'(ctrl_init), 0);
    chk("rst_run", 32'(ctrl_run), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bank", 32'(bank_sel), 0);
    chk("rst_count", 32'(frame_count), 0);
    chk("rst_irq", 32'({irq_done, irq_err, frame_done}), 0);

    // Single frame.
    sw_loop = 1'b0;
    start_run();
    run_frame(5, 3, 1'b0, 1'b0, 1'b0);
    chk("single_fd", 32'(frame_done), 1);
    chk("single_idle", 32'(busy), 0);
    chk("single_run_low", 32'(ctrl_run), 0);
    chk("single_count", 32'(frame_count), 1);
    cyc();
    chk("fd_one_cycle", 32'(frame_done), 0);
    chk("irq_done_set", 32'(irq_done), 1);

    // Looped frames with a 5-cycle gap, swap mid-RUN, stop in frame 3.
    sw_loop = 1'b1;
    sw_gap = 16'd5;
    start_run();
    run_frame(6, 2, 1'b1, 1'b0, 1'b0);
    measure_gap(5);
    run_frame(4, 4, 1'b0, 1'b0, 1'b0);
    measure_gap(5);
    run_frame(7, 3, 1'b0, 1'b0, 1'b1);
    chk("loop_stop_idle", 32'(busy), 0);
    chk("loop_count", 32'(frame_count), 3);

    // Zero gap with swap coincident with sync.
    sw_gap = 16'd0;
    start_run();
    run_frame(5, 2, 1'b0, 1'b1, 1'b0);
    measure_gap(0);
    run_frame(3, 3, 1'b0, 1'b0, 1'b0);
    measure_gap(0);
    run_frame(4, 2, 1'b0, 1'b0, 1'b1);
    chk("zero_gap_idle", 32'(busy), 0);

    // Abort in SYNC with a swap pending.
    start_run();
    repeat (4) cyc();
    stream_pixel_of = 1'b1;
    cyc();
    stream_pixel_of = 1'b0;
    sw_swap = 1'b1;
    cyc();
    sw_swap = 1'b0;
    sw_abort = 1'b1;
    cyc();
    sw_abort = 1'b0;
    m_swap = 1'b0;
    chk("abort_run_low", 32'(ctrl_run), 0);
    chk("abort_idle", 32'(busy), 0);
    chk("abort_bank", 32'(bank_sel), 32'(m_bank));
    chk("abort_no_fd", 32'(frame_done), 0);
    repeat (3) cyc();
    sw_loop = 1'b0;
    start_run();
    run_frame(3, 2, 1'b0, 1'b0, 1'b0);

    // Flip the bank, then reset asynchronously mid-RUN.
    start_run();
    run_frame(4, 2, 1'b1, 1'b0, 1'b0);
    start_run();
    repeat (3) cyc();
    #3;
    rst = 1'b1;
    #1;
    m_bank = 1'b0;
    m_swap = 1'b0;
    m_count = '0;
    chk("arst_run", 32'(ctrl_run), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_bank", 32'(bank_sel), 0);
    chk("arst_count", 32'(frame_count), 0);
    chk("arst_irq", 32'(irq_done), 0);
    @(negedge clk7mhz);
    rst = 1'b0;
    cyc();

    // Watchdog in RUN; a start while busy must not restart the run.
    start_run();
    n = 0;
    while (ctrl_run && n < 300) begin
      sw_start = (n == 50);
      n++;
      cyc();
    end
    sw_start = 1'b0;
    chk("wdog_len", n, WDOG);
    chk("wdog_err", 32'(irq_err), 1);
    chk("wdog_idle", 32'(busy), 0);
    sw_irq_clr = 1'b1;
    cyc();
    sw_irq_clr = 1'b0;
    chk("irq_err_clr", 32'(irq_err), 0);

    // Clear coincident with frame_done: set wins.
    start_run();
    run_frame(4, 2, 1'b0, 1'b0, 1'b0);
    chk("fd_visible", 32'(frame_done), 1);
    sw_irq_clr = 1'b1;
    cyc();
    sw_irq_clr = 1'b0;
    chk("irq_done_set_wins", 32'(irq_done), 1);
    sw_irq_clr = 1'b1;
    cyc();
    sw_irq_clr = 1'b0;
    chk("irq_done_clr", 32'(irq_done), 0);

    // Randomized looped runs.
    sw_loop = 1'b1;
    for (int it = 0; it < 6; it++) begin
      gap = int'($urandom_range(0, 6));
      nf = int'($urandom_range(1, 4));
      sw_gap = 16'(gap);
      start_run();
      for (int f = 0; f < nf; f++) begin
        run_frame(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  f == nf - 1);
        if (f < nf - 1) measure_gap(gap);
      end
      chk("rand_idle", 32'(busy), 0);
      chk("rand_count", 32'(frame_count), nf);
      repeat (2) cyc();
    end

    repeat (3) cyc();
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
